// File: rtl/systolic_pkg.sv
// Shared defaults and width helpers for the output-stationary systolic array.
package systolic_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIM   = 10;

    // Accumulator holds a full unsigned product and wraps on overflow.
    function automatic int acc_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate processing element: forwards A right and B down,
// and keeps its own C[i][j] partial sum.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               a_in,
    input  logic [WIDTH-1:0]               b_in,
    output logic [WIDTH-1:0]               a_out,
    output logic [WIDTH-1:0]               b_out,
    output logic [acc_width(WIDTH)-1:0]    acc
);

    localparam int ACC_W = acc_width(WIDTH);

    // Both operands are zero-extended so the product keeps all 2*WIDTH bits.
    function automatic logic [ACC_W-1:0] umul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [ACC_W-1:0] a_ext;
        logic [ACC_W-1:0] b_ext;
        a_ext = {{(ACC_W-WIDTH){1'b0}}, a};
        b_ext = {{(ACC_W-WIDTH){1'b0}}, b};
        return a_ext * b_ext;
    endfunction

    logic [ACC_W-1:0] prod_p0;

    always_comb begin
        prod_p0 = umul(a_in, b_in);
    end

    // Stage p0 -> p1: operands move on to neighbours, product folds into acc.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_p0;
        end
    end

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic array computing C = A x B from
// pre-skewed A rows (left edge) and B columns (top edge).
module systolic_array
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIM   = DEF_DIM
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            inp_left [DIM],
    input  logic [WIDTH-1:0]            inp_top  [DIM],
    output logic [acc_width(WIDTH)-1:0] result   [DIM][DIM]
);

    // a_bus[i][j] is the A operand entering PE(i,j); column DIM collects the
    // right-edge outputs, which nothing consumes. b_bus mirrors this downward.
    logic [WIDTH-1:0] a_bus [DIM][DIM+1];
    logic [WIDTH-1:0] b_bus [DIM+1][DIM];

    genvar i, j;
    generate
        for (i = 0; i < DIM; i++) begin : g_edge
            assign a_bus[i][0] = inp_left[i];
            assign b_bus[0][i] = inp_top[i];
        end

        for (i = 0; i < DIM; i++) begin : g_row
            for (j = 0; j < DIM; j++) begin : g_col
                systolic_pe #(
                    .WIDTH (WIDTH)
                ) u_pe (
                    .clock (clock),
                    .reset (reset),
                    .a_in  (a_bus[i][j]),
                    .b_in  (b_bus[i][j]),
                    .a_out (a_bus[i][j+1]),
                    .b_out (b_bus[i+1][j]),
                    .acc   (result[i][j])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for systolic_array (WIDTH=8, DIM=10).
module tb_systolic_array;

    localparam int W  = 8;
    localparam int D  = 10;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  inp_left [D];
    logic [W-1:0]  inp_top  [D];
    logic [AW-1:0] result   [D][D];

    int checks   = 0;
    int failures = 0;

    int unsigned mat_a [D][D];
    int unsigned mat_b [D][D];
    int unsigned exp_r [D][D];
    int m_dim, k_dim, n_dim;

    systolic_array #(
        .WIDTH (W),
        .DIM   (D)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .inp_left (inp_left),
        .inp_top  (inp_top),
        .result   (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j),
                      {16'd0, result[i][j]}, exp_r[i][j]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                mat_a[i][j] = 0;
                mat_b[i][j] = 0;
                exp_r[i][j] = 0;
            end
    endtask

    task automatic drive_lanes(input logic [W-1:0] v);
        for (int i = 0; i < D; i++) begin
            inp_left[i] = v;
            inp_top[i]  = v;
        end
    endtask

    // Skewed feed: A[i][k] on row i at cycle k+i, B[k][j] on column j at cycle k+j.
    task automatic set_cycle(input int t);
        drive_lanes('0);
        for (int i = 0; i < m_dim; i++)
            if (t - i >= 0 && t - i < n_dim)
                inp_left[i] = W'(mat_a[i][t-i]);
        for (int j = 0; j < k_dim; j++)
            if (t - j >= 0 && t - j < n_dim)
                inp_top[j] = W'(mat_b[t-j][j]);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_feed(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            set_cycle(t);
            step();
        end
        drive_lanes('0);
    endtask

    // Leaves reset released #1 after an edge, so the next edge is cycle 0.
    task automatic start_product();
        reset = 1'b1;
        drive_lanes('0);
        step();
        reset = 1'b0;
    endtask

    task automatic load_3x3x4();
        clear_model();
        m_dim = 3; n_dim = 3; k_dim = 4;
        mat_a[0][0] = 2; mat_a[0][1] = 3; mat_a[0][2] = 9;
        mat_a[1][0] = 1; mat_a[1][1] = 1; mat_a[1][2] = 5;
        mat_a[2][0] = 5; mat_a[2][1] = 1; mat_a[2][2] = 0;
        mat_b[0][0] = 2; mat_b[0][1] = 6; mat_b[0][2] = 1; mat_b[0][3] = 4;
        mat_b[1][0] = 0; mat_b[1][1] = 2; mat_b[1][2] = 2; mat_b[1][3] = 5;
        mat_b[2][0] = 9; mat_b[2][1] = 1; mat_b[2][2] = 8; mat_b[2][3] = 2;
        exp_r[0][0] = 85; exp_r[0][1] = 27; exp_r[0][2] = 80; exp_r[0][3] = 41;
        exp_r[1][0] = 47; exp_r[1][1] = 13; exp_r[1][2] = 43; exp_r[1][3] = 19;
        exp_r[2][0] = 10; exp_r[2][1] = 32; exp_r[2][2] = 7;  exp_r[2][3] = 25;
    endtask

    initial begin
        reset = 1'b1;
        drive_lanes(8'hA5);
        m_dim = 0; n_dim = 0; k_dim = 0;
        clear_model();

        // Reset held with busy inputs, then idle zeros after release.
        repeat (5) step();
        compare_all("rst_hold");
        reset = 1'b0;
        drive_lanes('0);
        repeat (3) step();
        compare_all("rst_idle");

        // 3x3 by 3x4 product; last entry C[2][3] is final after edge 7.
        load_3x3x4();
        start_product();
        run_feed(12);
        compare_all("mm3x4");
        repeat (3) step();
        compare_all("mm3x4_hold");

        // Asynchronous reset mid-feed clears everything before the next edge.
        start_product();
        for (int t = 0; t < 4; t++) begin
            set_cycle(t);
            step();
        end
        #3;
        reset = 1'b1;
        #1;
        begin
            int unsigned saved [D][D];
            saved = exp_r;
            clear_model();
            compare_all("mid_rst");
            load_3x3x4();
            if (saved != exp_r) $display("note: model reload differs");
        end
        drive_lanes('0);
        step();
        reset = 1'b0;
        run_feed(12);
        compare_all("mm3x4_rerun");

        // Identity times B: C[9][9] is final after edge 27.
        clear_model();
        m_dim = D; n_dim = D; k_dim = D;
        for (int i = 0; i < D; i++) begin
            mat_a[i][i] = 1;
            for (int j = 0; j < D; j++) begin
                mat_b[i][j] = (i * 37 + j * 11 + 5) % 256;
                exp_r[i][j] = mat_b[i][j];
            end
        end
        exp_r[9][9] = 255;
        mat_b[9][9] = 255;
        start_product();
        run_feed(30);
        compare_all("ident");

        // Two 255*255 products into PE(0,0) wrap modulo 2^16.
        clear_model();
        m_dim = 1; n_dim = 2; k_dim = 1;
        mat_a[0][0] = 255; mat_a[0][1] = 255;
        mat_b[0][0] = 255; mat_b[1][0] = 255;
        exp_r[0][0] = 64514;
        start_product();
        run_feed(5);
        compare_all("wrap");

        // Row-2 pulse at cycle 2 and column-5 pulse at cycle 5 meet only in PE(2,5) at edge 7.
        clear_model();
        exp_r[2][5] = 12;
        start_product();
        for (int t = 0; t < 20; t++) begin
            drive_lanes('0);
            if (t == 2) inp_left[2] = 8'd3;
            if (t == 5) inp_top[5]  = 8'd4;
            step();
        end
        compare_all("latency");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
